// File: rtl/bcd_pkg.sv
// Shared constants and types for the AHB binary-to-BCD converter.
// Register map, status bit positions, FSM states and saturation limit.
package bcd_pkg;

    localparam logic [1:0] REG_FRAC   = 2'd0;
    localparam logic [1:0] REG_START  = 2'd0;
    localparam logic [1:0] REG_INT    = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_SAT  = 2;

    localparam int unsigned MAX_VALUE  = 99999;
    localparam int unsigned BCD_DIGITS = 5;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5,
// then shift the {accumulator, binary} vector left by one bit.
module bcd_dabble_step #(
    parameter int unsigned DIGITS = 5,
    parameter int unsigned BIN_W  = 17
) (
    input  logic [4*DIGITS+BIN_W-1:0] din,
    output logic [4*DIGITS+BIN_W-1:0] dout
);

    localparam int unsigned W = 4 * DIGITS + BIN_W;

    logic [W-1:0] adj;

    always_comb begin
        adj = din;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (din[BIN_W+4*i +: 4] >= 4'd5) begin
                adj[BIN_W+4*i +: 4] = din[BIN_W+4*i +: 4] + 4'd3;
            end
        end
        dout = {adj[W-2:0], 1'b0};
    end

endmodule

// File: rtl/bcd_converter.sv
// AHB-Lite slave converting a saturated binary value in hundredths
// into packed BCD integer and fraction registers via double dabble.
module bcd_converter #(
    parameter int unsigned CONV_BITS = 17,
    parameter int unsigned MAX_VALUE = bcd_pkg::MAX_VALUE
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic        HSEL,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        BUSY
);

    import bcd_pkg::*;

    localparam int unsigned ACC_W = 4 * BCD_DIGITS;
    localparam int unsigned W     = ACC_W + CONV_BITS;
    localparam logic [4:0]  LAST  = 5'(CONV_BITS - 1);
    localparam logic [31:0] MAX_W = 32'(MAX_VALUE);

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic [W-1:0] sr;
    logic [W-1:0] sr_step;
    logic [1:0]  addr_q;
    logic        write_q;
    logic        valid_q;
    logic [7:0]  frac_q;
    logic [11:0] int_q;
    logic        sat_q;
    logic        done_q;

    logic        accept;
    logic        start;
    logic        stat_rd;
    logic        last_step;
    logic        sat_in;
    logic [31:0] load_val;

    logic        unused;
    assign unused = ^{HADDR[31:4], HADDR[1:0], HSIZE};

    assign HREADYOUT = 1'b1;

    assign accept   = HSEL && HREADY && (HTRANS != HTRANS_IDLE);
    assign start    = valid_q && write_q && (addr_q == REG_START);
    assign stat_rd  = valid_q && !write_q && (addr_q == REG_STATUS);
    assign sat_in   = HWDATA > MAX_W;
    assign load_val = sat_in ? MAX_W : HWDATA;

    // A restarting write takes precedence over finishing the old run
    assign last_step = (state == CONVERT) && (cnt == LAST) && !start;

    bcd_dabble_step #(
        .DIGITS (BCD_DIGITS),
        .BIN_W  (CONV_BITS)
    ) u_step (
        .din  (sr),
        .dout (sr_step)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q  <= 2'd0;
            write_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= accept;
            if (accept) begin
                addr_q  <= HADDR[3:2];
                write_q <= HWRITE;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = CONVERT;
            end
            CONVERT: begin
                if (start)            state_nxt = CONVERT;
                else if (cnt == LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state == CONVERT);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt <= 5'd0;
            sr  <= '0;
        end else if (start) begin
            cnt <= 5'd0;
            sr  <= {{ACC_W{1'b0}}, load_val[CONV_BITS-1:0]};
        end else if (state == CONVERT) begin
            cnt <= (cnt == LAST) ? 5'd0 : cnt + 5'd1;
            sr  <= sr_step;
        end
    end

    // Status read clears DONE first so a same-edge completion wins
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            frac_q <= 8'd0;
            int_q  <= 12'd0;
            sat_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (stat_rd) done_q <= 1'b0;
            if (start) begin
                sat_q  <= sat_in;
                done_q <= 1'b0;
            end
            if (last_step) begin
                int_q  <= sr_step[W-1 -: 12];
                frac_q <= sr_step[W-13 -: 8];
                done_q <= 1'b1;
            end
        end
    end

    always_comb begin
        HRDATA = 32'd0;
        unique case (addr_q)
            REG_FRAC:   HRDATA[7:0]  = frac_q;
            REG_INT:    HRDATA[11:0] = int_q;
            REG_STATUS: begin
                HRDATA[ST_SAT]  = sat_q;
                HRDATA[ST_DONE] = done_q;
                HRDATA[ST_BUSY] = BUSY;
            end
            default:    HRDATA = 32'd0;
        endcase
    end

endmodule
